// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S source arbiter: default sample width,
// source-selection modes and the saturation limits of a default-width sample.
package i2s_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SRC0 = 2'b00,
    MODE_SRC1 = 2'b01,
    MODE_MIX  = 2'b10,
    MODE_PRIO = 2'b11
  } mode_e;

  localparam logic [DW_DEF-1:0] SAT_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
  localparam logic [DW_DEF-1:0] SAT_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

endpackage

// File: rtl/i2s_sat_add.sv
// Combinational two's-complement adder that clamps to the representable
// DW-bit range instead of wrapping.
module i2s_sat_add
  import i2s_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum
);

  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  logic [DW:0] wide;

  assign wide = {a[DW-1], a} + {b[DW-1], b};

  // The two top bits of the extended sum disagree exactly on overflow;
  // the extra sign bit tells which way it went.
  always_comb begin
    sum = wide[DW-1:0];
    if (wide[DW] != wide[DW-1]) begin
      sum = wide[DW] ? SMIN : SMAX;
    end
  end

endmodule

// File: rtl/i2s_src_arb.sv
// Shares the transmitter's stereo sample input between two sources (select,
// priority or saturating mix), with mute, a one-entry output register and an
// overrun event counter.
module i2s_src_arb
  import i2s_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int OVR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_mute,
  input  logic [DW-1:0]        s0_lft,
  input  logic [DW-1:0]        s0_rgt,
  input  logic                 s0_rts,
  output logic                 s0_rtr,
  input  logic [DW-1:0]        s1_lft,
  input  logic [DW-1:0]        s1_rgt,
  input  logic                 s1_rts,
  output logic                 s1_rtr,
  output logic [DW-1:0]        dout_lft,
  output logic [DW-1:0]        dout_rgt,
  output logic                 dout_rts,
  input  logic                 dout_rtr,
  input  logic                 fifo_overun,
  output logic [OVR_CNT_W-1:0] ovr_cnt,
  input  logic                 ovr_clr
);

  mode_e         mode;
  logic          out_vld;
  logic [DW-1:0] out_lft;
  logic [DW-1:0] out_rgt;
  logic          load_ok;
  logic          acc0;
  logic          acc1;
  logic          accept;
  logic [DW-1:0] mix_lft;
  logic [DW-1:0] mix_rgt;
  logic [DW-1:0] nxt_lft;
  logic [DW-1:0] nxt_rgt;
  logic          ovr_prev;
  logic [OVR_CNT_W-1:0] ovr_q;

  assign mode = mode_e'(cfg_mode);

  // Holding rst out of load_ok keeps both sources untouched in a reset cycle.
  assign load_ok = !rst && en && (!out_vld || dout_rtr);

  always_comb begin
    s0_rtr = 1'b0;
    s1_rtr = 1'b0;
    case (mode)
      MODE_SRC0: s0_rtr = load_ok;
      MODE_SRC1: s1_rtr = load_ok;
      MODE_MIX: begin
        s0_rtr = load_ok && s0_rts && s1_rts;
        s1_rtr = load_ok && s0_rts && s1_rts;
      end
      MODE_PRIO: begin
        s0_rtr = load_ok;
        s1_rtr = load_ok && !s0_rts;
      end
    endcase
  end

  assign acc0   = s0_rts && s0_rtr;
  assign acc1   = s1_rts && s1_rtr;
  assign accept = acc0 || acc1;

  i2s_sat_add #(.DW(DW)) u_add_lft (.a(s0_lft), .b(s1_lft), .sum(mix_lft));
  i2s_sat_add #(.DW(DW)) u_add_rgt (.a(s0_rgt), .b(s1_rgt), .sum(mix_rgt));

  // Source 1 is only ever accepted alone when source 0 was not, so acc0
  // is enough to pick between the two single-source cases.
  always_comb begin
    nxt_lft = s1_lft;
    nxt_rgt = s1_rgt;
    if (mode == MODE_MIX) begin
      nxt_lft = mix_lft;
      nxt_rgt = mix_rgt;
    end else if (acc0) begin
      nxt_lft = s0_lft;
      nxt_rgt = s0_rgt;
    end
    if (cfg_mute) begin
      nxt_lft = '0;
      nxt_rgt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_lft <= '0;
      out_rgt <= '0;
    end else if (accept) begin
      out_vld <= 1'b1;
      out_lft <= nxt_lft;
      out_rgt <= nxt_rgt;
    end else if (out_vld && dout_rtr) begin
      out_vld <= 1'b0;
    end
  end

  // Only rising edges of the overrun flag count; a clear wins over a
  // coincident edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_prev <= 1'b0;
      ovr_q    <= '0;
    end else begin
      ovr_prev <= fifo_overun;
      if (ovr_clr) begin
        ovr_q <= '0;
      end else if (fifo_overun && !ovr_prev && (ovr_q != {OVR_CNT_W{1'b1}})) begin
        ovr_q <= ovr_q + 1'b1;
      end
    end
  end

  assign dout_rts = out_vld;
  assign dout_lft = out_lft;
  assign dout_rgt = out_rgt;
  assign ovr_cnt  = ovr_q;

endmodule

// File: tb/tb_i2s_src_arb.sv
// Randomised scoreboard bench for i2s_src_arb: a stimulus process predicts
// handshakes and samples, a negedge monitor checks whatever the DUT emits.
module tb_i2s_src_arb;
  import i2s_pkg::*;

  localparam int DW = 16;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    cfg_mode = 2'b00;
  logic          cfg_mute = 1'b0;
  logic [DW-1:0] s0_lft = '0, s0_rgt = '0, s1_lft = '0, s1_rgt = '0;
  logic          s0_rts = 1'b0, s1_rts = 1'b0;
  logic          s0_rtr, s1_rtr;
  logic [DW-1:0] dout_lft, dout_rgt;
  logic          dout_rts;
  logic          dout_rtr = 1'b0;
  logic          fifo_overun = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [OW-1:0] ovr_cnt;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } smp_t;

  smp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  bit            exp_vld = 1'b0;
  bit            in_reset = 1'b1;
  bit            stalled_prev = 1'b0;
  logic [DW-1:0] held_l, held_r;
  int            ovr_model = 0;
  bit            ovr_prev_model = 1'b0;

  always #5 clk = ~clk;

  i2s_src_arb #(.DW(DW), .OVR_CNT_W(OW)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_mode(cfg_mode), .cfg_mute(cfg_mute),
    .s0_lft(s0_lft), .s0_rgt(s0_rgt), .s0_rts(s0_rts), .s0_rtr(s0_rtr),
    .s1_lft(s1_lft), .s1_rgt(s1_rgt), .s1_rts(s1_rts), .s1_rtr(s1_rtr),
    .dout_lft(dout_lft), .dout_rgt(dout_rgt), .dout_rts(dout_rts), .dout_rtr(dout_rtr),
    .fifo_overun(fifo_overun), .ovr_cnt(ovr_cnt), .ovr_clr(ovr_clr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mixCh(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    int hi;
    int lo;
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    s = int'($signed(a)) + int'($signed(b));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s[DW-1:0];
  endfunction

  // One clock of source-side stimulus; predicts handshakes from the rules
  // and queues the sample the transmitter should eventually receive.
  task automatic applyStimulus(input bit e, input logic [1:0] m, input bit mu,
                               input logic [DW-1:0] a0l, input logic [DW-1:0] a0r, input bit r0,
                               input logic [DW-1:0] a1l, input logic [DW-1:0] a1r, input bit r1,
                               input bit orr);
    bit   load_ok, e0, e1;
    smp_t s;
    @(posedge clk);
    #1;
    en = e; cfg_mode = m; cfg_mute = mu;
    s0_lft = a0l; s0_rgt = a0r; s0_rts = r0;
    s1_lft = a1l; s1_rgt = a1r; s1_rts = r1;
    dout_rtr = orr;
    #1;
    exp_vld = (sb.size() != 0);
    load_ok = e && (!exp_vld || orr);
    e0 = 1'b0;
    e1 = 1'b0;
    case (m)
      2'b00: e0 = load_ok;
      2'b01: e1 = load_ok;
      2'b10: begin e0 = load_ok && r0 && r1; e1 = e0; end
      default: begin e0 = load_ok; e1 = load_ok && !r0; end
    endcase
    checkOutput("s0_rtr", s0_rtr, e0);
    checkOutput("s1_rtr", s1_rtr, e1);
    if ((e0 && r0) || (e1 && r1)) begin
      if (mu) begin
        s.l = '0; s.r = '0;
      end else if (m == 2'b10) begin
        s.l = mixCh(a0l, a1l); s.r = mixCh(a0r, a1r);
      end else if (e0 && r0) begin
        s.l = a0l; s.r = a0r;
      end else begin
        s.l = a1l; s.r = a1r;
      end
      sb.push_back(s);
    end
  endtask

  task automatic doReset();
    in_reset = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b1; cfg_mode = 2'b00; s0_rts = 1'b1; s1_rts = 1'b1; dout_rtr = 1'b0;
    #1;
    checkOutput("reset_s0_rtr", s0_rtr, 0);
    checkOutput("reset_s1_rtr", s1_rtr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0; s0_rts = 1'b0; s1_rts = 1'b0;
    sb.delete();
    exp_vld = 1'b0;
    stalled_prev = 1'b0;
    checkOutput("reset_dout_rts", dout_rts, 0);
    checkOutput("reset_dout_lft", dout_lft, 0);
    checkOutput("reset_dout_rgt", dout_rgt, 0);
    in_reset = 1'b0;
  endtask

  task automatic ovrStep(input bit f, input bit c);
    @(posedge clk);
    #1;
    fifo_overun = f; ovr_clr = c;
    if (c) ovr_model = 0;
    else if (f && !ovr_prev_model && ovr_model < (1 << OW) - 1) ovr_model++;
    ovr_prev_model = f;
    @(posedge clk);
    #1;
    checkOutput("ovr_cnt", ovr_cnt, ovr_model);
  endtask

  function automatic logic [DW-1:0] rndData();
    case ($urandom % 4)
      0: return ($urandom % 2) ? SAT_MAX : SAT_MIN;
      default: return DW'($urandom);
    endcase
  endfunction

  // Monitor: checks occupancy, stall stability and each transferred sample.
  always @(negedge clk) begin
    if (!in_reset) begin
      checkOutput("dout_rts", dout_rts, exp_vld);
      if (stalled_prev && dout_rts) begin
        checkOutput("stall_lft", dout_lft, held_l);
        checkOutput("stall_rgt", dout_rgt, held_r);
      end
      if (dout_rts && dout_rtr) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          smp_t s;
          s = sb.pop_front();
          checkOutput("dout_lft", dout_lft, s.l);
          checkOutput("dout_rgt", dout_rgt, s.r);
        end
      end
      stalled_prev = dout_rts && !dout_rtr;
      held_l = dout_lft;
      held_r = dout_rgt;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_ovr_cnt", ovr_cnt, 0);
    doReset();

    // single source 0, source 1 never served
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 2'b00, 0, 16'h1234 + DW'(i), 16'h5678, 1, 16'h1111, 16'h2222, 1, 1);
    applyStimulus(1, 2'b00, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 1);

    // priority: both ready -> only src0; then src1
    applyStimulus(1, 2'b11, 0, 16'hAAAA, 16'hBBBB, 1, 16'hCCCC, 16'hDDDD, 1, 1);
    applyStimulus(1, 2'b11, 0, 16'hAAAB, 16'hBBBC, 1, 16'hCCCC, 16'hDDDD, 1, 1);
    applyStimulus(1, 2'b11, 0, 16'h0, 16'h0, 0, 16'hCCCC, 16'hDDDD, 1, 1);

    // mix with saturation, then a half-ready pair that must not be taken
    applyStimulus(1, 2'b10, 0, 16'h7000, 16'h8000, 1, 16'h2000, 16'h9000, 1, 1);
    applyStimulus(1, 2'b10, 0, 16'h0100, 16'hFF00, 1, 16'h0200, 16'h0001, 1, 1);
    applyStimulus(1, 2'b10, 0, 16'h0100, 16'h0100, 1, 16'h0, 16'h0, 0, 1);

    // stall for 5 cycles, then back-to-back transfers
    applyStimulus(1, 2'b00, 0, 16'h5A5A, 16'hA5A5, 1, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 2'b00, 0, 16'h6000, 16'h6001, 1, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 2'b00, 0, 16'h6000 + DW'(i), 16'h7000 - DW'(i), 1, 16'h0, 16'h0, 0, 1);

    // mute, then enable low while a sample drains
    applyStimulus(1, 2'b00, 1, 16'h4321, 16'h4321, 1, 16'h0, 16'h0, 0, 0);
    applyStimulus(0, 2'b00, 0, 16'h1357, 16'h2468, 1, 16'h0, 16'h0, 1, 1);
    applyStimulus(0, 2'b11, 0, 16'h1357, 16'h2468, 1, 16'h0, 16'h0, 1, 1);

    // reset while a sample is held
    applyStimulus(1, 2'b01, 0, 16'h0, 16'h0, 0, 16'hBEEF, 16'hCAFE, 1, 0);
    doReset();

    for (int i = 0; i < 1500; i++)
      applyStimulus(($urandom % 8) != 0, 2'($urandom), ($urandom % 10) == 0,
                    rndData(), rndData(), ($urandom % 3) != 0,
                    rndData(), rndData(), ($urandom % 3) != 0,
                    ($urandom % 4) != 0);

    for (int i = 0; i < 3; i++)
      applyStimulus(0, 2'b00, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 1);
    @(negedge clk);
    checkOutput("drain_empty", sb.size(), 0);

    // overrun counter: saturation, held level, clear beating an edge
    for (int i = 0; i < 300; i++) begin
      ovrStep(1, 0);
      ovrStep(0, 0);
    end
    checkOutput("ovr_saturated", ovr_cnt, 255);
    ovrStep(1, 1);
    ovrStep(0, 0);
    ovrStep(1, 0);
    ovrStep(1, 0);
    ovrStep(0, 0);
    ovrStep(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
